// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: two-flop input synchroniser followed by a
// mid-bit sampling frame decoder with optional parity and one or two stop
// bits. Each decoded word is presented with a one-cycle valid strobe and
// parity / framing / break flags that hold until the next strobe.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 278,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  output logic [DATA_BITS-1:0] data_rx,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 brk,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = 4;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF    = CW'(CLKS_PER_BIT / 2);
  localparam logic [IW-1:0] LAST_D  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_S  = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_IDLE} state_t;

  state_t                 state, state_n;
  logic                   din_s1, din_s2;
  logic [CW-1:0]          cnt, cnt_n;
  logic [IW-1:0]          idx, idx_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n;
  logic                   par_bit, par_n;
  logic                   ferr, ferr_n;
  logic                   tick;
  logic                   done;

  // Parity check of the received word against the received parity bit.
  function automatic logic parity_check(input logic [DATA_BITS-1:0] d, input logic p);
    if (PARITY == 1)      return ~(^d ^ p);
    else if (PARITY == 2) return ^d ^ p;
    else                  return 1'b0;
  endfunction

  // Break: a framing error with every data bit and the parity bit sampled low.
  function automatic logic break_check(input logic fe, input logic [DATA_BITS-1:0] d,
                                       input logic p);
    return fe & ~(|d) & ~p;
  endfunction

  assign tick = (cnt == CNT_MAX);
  assign busy = (state != IDLE);

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_s1 <= 1'b1;
      din_s2 <= 1'b1;
    end else begin
      din_s1 <= din;
      din_s2 <= din_s1;
    end
  end

  // Frame decoder control: state, bit-period counter, bit index, stop error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      ferr  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      ferr  <= ferr_n;
    end
  end

  // Received data shift register and parity bit; qualified by the FSM.
  always_ff @(posedge clk) begin
    shreg   <= shreg_n;
    par_bit <= par_n;
  end

  // Next-state logic. START is entered with the counter at 1 so the start
  // bit is checked HALF+2 edges after din_s1 first sees it low.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    par_n   = par_bit;
    ferr_n  = ferr;
    done    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (!din_s2) begin
          state_n = START;
          cnt_n   = CW'(1);
          ferr_n  = 1'b0;
          par_n   = 1'b0;
        end
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n   = '0;
          state_n = din_s2 ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_n   = '0;
          shreg_n = {din_s2, shreg[DATA_BITS-1:1]};
          if (idx == LAST_D) begin
            idx_n   = '0;
            state_n = (PARITY != 0) ? PAR : STOP;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PAR: begin
        if (tick) begin
          cnt_n   = '0;
          par_n   = din_s2;
          state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          cnt_n = '0;
          if (!din_s2) ferr_n = 1'b1;
          if (idx == LAST_S) begin
            idx_n   = '0;
            done    = 1'b1;
            state_n = din_s2 ? IDLE : WAIT_IDLE;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        cnt_n = '0;
        if (din_s2) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Result register: loaded on the final stop sample, held until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_rx    <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      brk        <= 1'b0;
    end else begin
      valid <= done;
      if (done) begin
        data_rx    <= shreg;
        parity_err <= parity_check(shreg, par_bit);
        frame_err  <= ferr_n;
        brk        <= break_check(ferr_n, shreg, par_bit);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: four receiver configurations sharing one clock.
// u0 defaults (278 clk/bit), u1 even parity 7 data bits, u2 two stop bits,
// u3 odd parity 5 data bits (u1..u3 at 16 clk/bit).
module tb_uart_rx_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din0 = 1'b1, din1 = 1'b1, din2 = 1'b1, din3 = 1'b1;
  logic [7:0] data0;
  logic [6:0] data1;
  logic [7:0] data2;
  logic [4:0] data3;
  logic valid0, valid1, valid2, valid3;
  logic perr0, perr1, perr2, perr3;
  logic ferr0, ferr1, ferr2, ferr3;
  logic brk0, brk1, brk2, brk3;
  logic busy0, busy1, busy2, busy3;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  int         vcount [4];
  int         vcyc   [4];
  logic [8:0] vdata  [4];
  logic       vperr  [4];
  logic       vferr  [4];
  logic       vbrk   [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.CLKS_PER_BIT(278), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .din(din0), .data_rx(data0), .valid(valid0),
    .parity_err(perr0), .frame_err(ferr0), .brk(brk0), .busy(busy0));
  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .din(din1), .data_rx(data1), .valid(valid1),
    .parity_err(perr1), .frame_err(ferr1), .brk(brk1), .busy(busy1));
  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .din(din2), .data_rx(data2), .valid(valid2),
    .parity_err(perr2), .frame_err(ferr2), .brk(brk2), .busy(busy2));
  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(5), .PARITY(1), .STOP_BITS(1)) u3 (
    .clk(clk), .rst(rst), .din(din3), .data_rx(data3), .valid(valid3),
    .parity_err(perr3), .frame_err(ferr3), .brk(brk3), .busy(busy3));

  // Capture every valid strobe, away from the active edge.
  always @(negedge clk) begin
    if (valid0) begin vcount[0]++; vcyc[0] = cyc; vdata[0] = {1'b0, data0};
      vperr[0] = perr0; vferr[0] = ferr0; vbrk[0] = brk0; end
    if (valid1) begin vcount[1]++; vcyc[1] = cyc; vdata[1] = {2'b0, data1};
      vperr[1] = perr1; vferr[1] = ferr1; vbrk[1] = brk1; end
    if (valid2) begin vcount[2]++; vcyc[2] = cyc; vdata[2] = {1'b0, data2};
      vperr[2] = perr2; vferr[2] = ferr2; vbrk[2] = brk2; end
    if (valid3) begin vcount[3]++; vcyc[3] = cyc; vdata[3] = {4'b0, data3};
      vperr[3] = perr3; vferr[3] = ferr3; vbrk[3] = brk3; end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_din(input int unit, input logic v);
    case (unit)
      0: din0 = v;
      1: din1 = v;
      2: din2 = v;
      default: din3 = v;
    endcase
  endtask

  // Start bit, then nb bits LSB first, each cpb cycles. Called #1 after a posedge.
  task automatic send(input int unit, input int cpb, input logic [15:0] bits, input int nb);
    set_din(unit, 1'b0);
    repeat (cpb) @(posedge clk);
    #1;
    for (int i = 0; i < nb; i++) begin
      set_din(unit, bits[i]);
      repeat (cpb) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          unit;
    logic [15:0] bits;
    int          nbits;
    logic [8:0]  exp_data;
    logic        exp_perr;
    logic        exp_ferr;
    logic        exp_brk;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int t0, t1, c0, busy_cnt;
    logic seen_busy;

    // bits = {stops, parity, data} LSB first
    vecs[0]  = '{1, 16'h0155, 9, 9'h055, 1'b0, 1'b0, 1'b0}; // 0x55 even par ok
    vecs[1]  = '{1, 16'h01D5, 9, 9'h055, 1'b1, 1'b0, 1'b0}; // 0x55 wrong par
    vecs[2]  = '{1, 16'h01FF, 9, 9'h07F, 1'b0, 1'b0, 1'b0}; // 0x7F par 1
    vecs[3]  = '{1, 16'h0180, 9, 9'h000, 1'b1, 1'b0, 1'b0}; // 0x00 par 1 wrong
    vecs[4]  = '{1, 16'h00A3, 9, 9'h023, 1'b0, 1'b1, 1'b0}; // stop low
    vecs[5]  = '{1, 16'h0000, 9, 9'h000, 1'b0, 1'b1, 1'b1}; // break shape
    vecs[6]  = '{1, 16'h0080, 9, 9'h000, 1'b1, 1'b1, 1'b0}; // par 1 blocks brk
    vecs[7]  = '{3, 16'h0055, 7, 9'h015, 1'b0, 1'b0, 1'b0}; // odd par ok
    vecs[8]  = '{3, 16'h0075, 7, 9'h015, 1'b1, 1'b0, 1'b0}; // odd par wrong
    vecs[9]  = '{3, 16'h0060, 7, 9'h000, 1'b0, 1'b0, 1'b0}; // zero, par 1 ok
    vecs[10] = '{3, 16'h0040, 7, 9'h000, 1'b1, 1'b0, 1'b0}; // zero, par 0 wrong
    vecs[11] = '{2, 16'h0281, 10, 9'h081, 1'b0, 1'b1, 1'b0}; // first stop low
    vecs[12] = '{2, 16'h0300, 10, 9'h000, 1'b0, 1'b0, 1'b0}; // clean zero

    for (int u = 0; u < 4; u++) vcount[u] = 0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", {24'b0, data0}, 32'h0);
    chk("rst_valid", {31'b0, valid0}, 32'h0);
    chk("rst_perr", {31'b0, perr0}, 32'h0);
    chk("rst_ferr", {31'b0, ferr0}, 32'h0);
    chk("rst_brk", {31'b0, brk0}, 32'h0);
    chk("rst_busy", {31'b0, busy0}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(10);

    // Basic frame and back-to-back on defaults
    c0 = vcount[0];
    t0 = cyc;
    send(0, 278, 16'h01A5, 9);
    chk("a5_count", vcount[0] - c0, 1);
    chk("a5_data", {23'b0, vdata[0]}, 32'hA5);
    chk("a5_flags", {29'b0, vperr[0], vferr[0], vbrk[0]}, 32'h0);
    // valid is registered at edge E0+2643; E0 is one edge after the drive
    chk("a5_latency", vcyc[0] - t0, 2643 + 1);
    t1 = vcyc[0];
    send(0, 278, 16'h013C, 9);
    chk("3c_count", vcount[0] - c0, 2);
    chk("3c_data", {23'b0, vdata[0]}, 32'h3C);
    chk("3c_flags", {29'b0, vperr[0], vferr[0], vbrk[0]}, 32'h0);
    chk("b2b_spacing", vcyc[0] - t1, 2780);
    idle(20);

    // Glitch rejection
    c0 = vcount[0];
    set_din(0, 1'b0);
    busy_cnt = 0;
    seen_busy = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i == 50) set_din(0, 1'b1);
      @(negedge clk);
      if (busy0) begin busy_cnt++; seen_busy = 1'b1; end
      @(posedge clk); #1;
    end
    chk("glitch_busy_seen", {31'b0, seen_busy}, 32'h1);
    chk("glitch_busy_short", {31'b0, (busy_cnt <= 141)}, 32'h1);
    chk("glitch_busy_end", {31'b0, busy0}, 32'h0);
    chk("glitch_no_valid", vcount[0] - c0, 0);

    // Break: line low for 30 bit times
    c0 = vcount[0];
    set_din(0, 1'b0);
    idle(30 * 278);
    chk("brk_count", vcount[0] - c0, 1);
    chk("brk_data", {23'b0, vdata[0]}, 32'h0);
    chk("brk_ferr", {31'b0, vferr[0]}, 32'h1);
    chk("brk_brk", {31'b0, vbrk[0]}, 32'h1);
    chk("brk_hold_busy", {31'b0, busy0}, 32'h1);
    set_din(0, 1'b1);
    idle(10);
    chk("brk_release_busy", {31'b0, busy0}, 32'h0);
    send(0, 278, 16'h0112, 9);
    chk("after_brk_count", vcount[0] - c0, 2);
    chk("after_brk_data", {23'b0, vdata[0]}, 32'h12);
    chk("after_brk_flags", {29'b0, vperr[0], vferr[0], vbrk[0]}, 32'h0);
    idle(20);

    // Reset mid-way through data bit 4 of 0x6B
    c0 = vcount[0];
    set_din(0, 1'b0); idle(278);
    set_din(0, 1'b1); idle(278);
    set_din(0, 1'b1); idle(278);
    set_din(0, 1'b0); idle(278);
    set_din(0, 1'b1); idle(278);
    set_din(0, 1'b0); idle(139);
    chk("pre_rst_busy", {31'b0, busy0}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_din(0, 1'b1);
    @(negedge clk);
    chk("mid_rst_data", {24'b0, data0}, 32'h0);
    chk("mid_rst_valid", {31'b0, valid0}, 32'h0);
    chk("mid_rst_busy", {31'b0, busy0}, 32'h0);
    chk("mid_rst_flags", {29'b0, perr0, ferr0, brk0}, 32'h0);
    idle(300);
    chk("mid_rst_no_valid", vcount[0] - c0, 0);
    send(0, 278, 16'h01FF, 9);
    chk("ff_count", vcount[0] - c0, 1);
    chk("ff_data", {23'b0, vdata[0]}, 32'hFF);
    chk("ff_flags", {29'b0, vperr[0], vferr[0], vbrk[0]}, 32'h0);
    idle(20);

    // Table-driven vectors on the short-bit-time units
    for (int v = 0; v < 13; v++) begin
      c0 = vcount[vecs[v].unit];
      send(vecs[v].unit, 16, vecs[v].bits, vecs[v].nbits);
      set_din(vecs[v].unit, 1'b1);
      idle(48);
      chk($sformatf("vec%0d_count", v), vcount[vecs[v].unit] - c0, 1);
      chk($sformatf("vec%0d_data", v), {23'b0, vdata[vecs[v].unit]}, {23'b0, vecs[v].exp_data});
      chk($sformatf("vec%0d_perr", v), {31'b0, vperr[vecs[v].unit]}, {31'b0, vecs[v].exp_perr});
      chk($sformatf("vec%0d_ferr", v), {31'b0, vferr[vecs[v].unit]}, {31'b0, vecs[v].exp_ferr});
      chk($sformatf("vec%0d_brk", v), {31'b0, vbrk[vecs[v].unit]}, {31'b0, vecs[v].exp_brk});
    end

    // Two stop bits, second one low: holds in WAIT_IDLE until the line rises
    c0 = vcount[2];
    send(2, 16, 16'h0181, 10);
    idle(40);
    chk("stop2_count", vcount[2] - c0, 1);
    chk("stop2_data", {23'b0, vdata[2]}, 32'h81);
    chk("stop2_ferr", {31'b0, vferr[2]}, 32'h1);
    chk("stop2_brk", {31'b0, vbrk[2]}, 32'h0);
    chk("stop2_wait_busy", {31'b0, busy2}, 32'h1);
    set_din(2, 1'b1);
    idle(5);
    chk("stop2_release_busy", {31'b0, busy2}, 32'h0);
    idle(60);
    chk("stop2_single", vcount[2] - c0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
